// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end that builds each 32-bit instruction from four byte reads.
// Optional IF_FETCH_ALIGN_CHECK_EN: word-align redirect targets and raise a sticky misalign flag.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        req_if,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    output logic        misalign
);

    typedef enum logic [0:0] {ST_FETCH = 1'b0, ST_HOLD = 1'b1} state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] buf_r;
    logic [31:0] buf_next_s;
    logic [31:0] target_pc_s;
    logic        redirect_s;
    logic        unused_stall_s;

    // A branch only takes effect in the cycle ID actually advances.
    assign redirect_s     = branch_flag & ~stall[2];
    assign unused_stall_s = ^{stall[5:3], stall[0]};

`ifdef IF_FETCH_ALIGN_CHECK_EN
    logic misalign_r;

    assign target_pc_s = {branch_target[31:2], 2'b00};

    // Sticky flag for a redirect to a non-word-aligned target.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
        end else if (redirect_s && (branch_target[1:0] != 2'b00)) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign misalign = misalign_r;
`else
    assign target_pc_s = branch_target;
    assign misalign    = 1'b0;
`endif

    // State register: pc, fetch FSM, byte counter and assembly buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_FETCH;
            cnt_r   <= 3'd0;
            pc_r    <= RESET_PC;
            buf_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            pc_r    <= pc_next_s;
            buf_r   <= buf_next_s;
        end
    end

    // Next-state logic: byte capture lags the request by one cycle, redirect overrides all.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pc_next_s    = pc_r;
        buf_next_s   = buf_r;
        case (state_r)
            ST_FETCH: begin
                case (cnt_r)
                    3'd1:    buf_next_s[7:0]   = mem_rdata;
                    3'd2:    buf_next_s[15:8]  = mem_rdata;
                    3'd3:    buf_next_s[23:16] = mem_rdata;
                    3'd4:    buf_next_s[31:24] = mem_rdata;
                    default: buf_next_s        = buf_r;
                endcase
                if (cnt_r >= 3'd4) begin
                    state_next_s = ST_HOLD;
                    cnt_next_s   = 3'd0;
                end else begin
                    cnt_next_s = cnt_r + 3'd1;
                end
            end
            ST_HOLD: begin
                if (!stall[1]) begin
                    pc_next_s    = pc_r + 32'd4;
                    state_next_s = ST_FETCH;
                    cnt_next_s   = 3'd0;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_FETCH;
                cnt_next_s   = 3'd0;
            end
        endcase
        if (redirect_s) begin
            pc_next_s    = target_pc_s;
            state_next_s = ST_FETCH;
            cnt_next_s   = 3'd0;
        end else begin
            pc_next_s = pc_next_s;
        end
    end

    // Outputs: req_if decodes registers only; a redirect in HOLD squashes the held word.
    always_comb begin
        req_if     = (state_r == ST_FETCH);
        mem_rd     = (state_r == ST_FETCH) && (cnt_r < 3'd4);
        mem_addr   = pc_r + {29'd0, cnt_r};
        inst_pc    = pc_r;
        inst       = NOP_INST;
        inst_valid = 1'b0;
        if ((state_r == ST_HOLD) && !redirect_s) begin
            inst       = buf_r;
            inst_valid = 1'b1;
        end else begin
            inst       = NOP_INST;
            inst_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: reset vector table, directed corner sequences, random run vs model.
module tb_if_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = 6'd0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        req_if, mem_rd, inst_valid, misalign;
    logic [31:0] mem_addr, inst, inst_pc;
    logic [7:0]  mem_rdata = 8'd0;

    int checks = 0;
    int errors = 0;

    if_fetch dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
        .branch_target(branch_target), .req_if(req_if), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .inst(inst),
        .inst_pc(inst_pc), .inst_valid(inst_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rb(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return (a[7:0] * 8'd7) ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {rb(a + 32'd3), rb(a + 32'd2), rb(a + 32'd1), rb(a)};
    endfunction

    // Byte RAM: data one cycle after the request; garbage when not read.
    always @(posedge clk) mem_rdata <= mem_rd ? rb(mem_addr) : 8'hEE;

    // Reference model: current instruction address and cycles spent on it (5+ means presented).
    logic [31:0] m_pc = 32'd0;
    int          m_age = 0;
    logic        m_mis = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 32'd0; m_age <= 0; m_mis <= 1'b0;
        end else if (branch_flag && !stall[2]) begin
            m_pc  <= ALIGN ? (branch_target & 32'hFFFF_FFFC) : branch_target;
            m_age <= 0;
            if (ALIGN && branch_target[1:0] != 2'b00) m_mis <= 1'b1;
        end else if (m_age >= 5) begin
            if (!stall[1]) begin
                m_pc <= m_pc + 32'd4; m_age <= 0;
            end
        end else begin
            m_age <= m_age + 1;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic hold, redir, val;
        hold  = (m_age >= 5);
        redir = branch_flag && !stall[2];
        val   = hold && !redir;
        chk32("req_if", {31'd0, req_if}, {31'd0, !hold});
        chk32("mem_rd", {31'd0, mem_rd}, {31'd0, (m_age < 4)});
        if (m_age < 4) chk32("mem_addr", mem_addr, m_pc + m_age);
        chk32("inst_valid", {31'd0, inst_valid}, {31'd0, val});
        chk32("inst", inst, val ? word_at(m_pc) : NOP);
        chk32("inst_pc", inst_pc, m_pc);
        chk32("misalign", {31'd0, misalign}, {31'd0, m_mis});
    endtask

    task automatic cycle(input logic r, input logic [5:0] s, input logic b, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; branch_flag = b; branch_target = t;
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 6'd0; branch_flag = 1'b0;
        @(posedge clk);
    endtask

    task automatic run_to_hold();
        int n = 0;
        while (!inst_valid && n < 12) begin
            cycle(1'b0, 6'b000010, 1'b0, 32'd0);
            n++;
        end
        chk32("reach_hold", {31'd0, inst_valid}, 32'd1);
    endtask

    typedef struct {
        logic [5:0]  stall;
        logic        bf;
        logic [31:0] tgt;
        logic        e_req;
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic [5:0] s, input logic rq, input logic rd,
                                input logic [31:0] a, input logic v, input logic [31:0] i,
                                input logic [31:0] p);
        vec_t x;
        x.stall = s; x.bf = 1'b0; x.tgt = 32'd0; x.e_req = rq; x.e_rd = rd;
        x.e_addr = a; x.e_valid = v; x.e_inst = i; x.e_pc = p;
        return x;
    endfunction

    initial begin
        // Cycles numbered from reset deassertion; HOLD stalled for cycles 5..7.
        tbl[0]  = mk(6'b000000, 1, 1, 32'd0, 0, NOP, 32'd0);
        tbl[1]  = mk(6'b111111, 1, 1, 32'd1, 0, NOP, 32'd0);
        tbl[2]  = mk(6'b000010, 1, 1, 32'd2, 0, NOP, 32'd0);
        tbl[3]  = mk(6'b000000, 1, 1, 32'd3, 0, NOP, 32'd0);
        tbl[4]  = mk(6'b000000, 1, 0, 32'd0, 0, NOP, 32'd0);
        tbl[5]  = mk(6'b000111, 0, 0, 32'd0, 1, 32'h0010_0513, 32'd0);
        tbl[6]  = mk(6'b000111, 0, 0, 32'd0, 1, 32'h0010_0513, 32'd0);
        tbl[7]  = mk(6'b000111, 0, 0, 32'd0, 1, 32'h0010_0513, 32'd0);
        tbl[8]  = mk(6'b000000, 0, 0, 32'd0, 1, 32'h0010_0513, 32'd0);
        tbl[9]  = mk(6'b000000, 1, 1, 32'd4, 0, NOP, 32'd4);
        tbl[10] = mk(6'b000000, 1, 1, 32'd5, 0, NOP, 32'd4);
        tbl[11] = mk(6'b000000, 1, 1, 32'd6, 0, NOP, 32'd4);
        tbl[12] = mk(6'b000000, 1, 1, 32'd7, 0, NOP, 32'd4);
        tbl[13] = mk(6'b000000, 1, 0, 32'd0, 0, NOP, 32'd4);
        tbl[14] = mk(6'b000000, 0, 0, 32'd0, 1, word_at(32'd4), 32'd4);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, tbl[i].stall, tbl[i].bf, tbl[i].tgt);
            chk32($sformatf("t%0d_req_if", i), {31'd0, req_if}, {31'd0, tbl[i].e_req});
            chk32($sformatf("t%0d_mem_rd", i), {31'd0, mem_rd}, {31'd0, tbl[i].e_rd});
            if (tbl[i].e_rd) chk32($sformatf("t%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
            chk32($sformatf("t%0d_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_valid});
            chk32($sformatf("t%0d_inst", i), inst, tbl[i].e_inst);
            chk32($sformatf("t%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
        end

        // Redirect at cnt=2 aborts the fetch; the new word holds only bytes from the target.
        do_reset();
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        cycle(1'b0, 6'd0, 1'b1, 32'h100);
        chk32("abort_addr", mem_addr, 32'd2);
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        chk32("redir_addr", mem_addr, 32'h100);
        for (int i = 0; i < 4; i++) cycle(1'b0, 6'd0, 1'b0, 32'd0);
        cycle(1'b0, 6'b000010, 1'b0, 32'd0);
        chk32("redir_inst_pc", inst_pc, 32'h100);
        chk32("redir_inst", inst, word_at(32'h100));

        // Redirect in HOLD together with an IF stall: squash now, target next.
        cycle(1'b0, 6'b000010, 1'b1, 32'h300);
        chk32("squash_inst", inst, NOP);
        chk32("squash_valid", {31'd0, inst_valid}, 32'd0);
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        chk32("squash_next_pc", inst_pc, 32'h300);

        // Branch held off while ID is stalled, taken once it advances.
        cycle(1'b0, 6'b000100, 1'b1, 32'h200);
        chk32("held_br_addr1", mem_addr, 32'h301);
        cycle(1'b0, 6'b000100, 1'b1, 32'h200);
        chk32("held_br_addr2", mem_addr, 32'h302);
        cycle(1'b0, 6'd0, 1'b1, 32'h200);
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        chk32("held_br_taken", mem_addr, 32'h200);

        // Misaligned target.
        cycle(1'b0, 6'd0, 1'b1, 32'h102);
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        chk32("mis_addr", mem_addr, ALIGN ? 32'h100 : 32'h102);
        chk32("mis_flag", {31'd0, misalign}, {31'd0, ALIGN});
        run_to_hold();
        chk32("mis_word", inst, ALIGN ? word_at(32'h100) : word_at(32'h102));

        // PC wraps past the top of the address space.
        cycle(1'b0, 6'd0, 1'b1, 32'hFFFF_FFFC);
        run_to_hold();
        chk32("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        chk32("wrap_addr", mem_addr, 32'd0);

        // Reset clears the sticky flag.
        do_reset();
        cycle(1'b0, 6'd0, 1'b0, 32'd0);
        chk32("rst_misalign", {31'd0, misalign}, 32'd0);
        chk32("rst_addr", mem_addr, 32'd0);

        // Random run against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] t;
            t = $urandom();
            if ($urandom_range(0, 1) == 0) t = {24'd0, t[7:0]};
            cycle(($urandom_range(0, 99) == 0), 6'($urandom()),
                  ($urandom_range(0, 9) == 0), t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage front end: owns the PC, fetches each 32-bit instruction from the byte-wide instruction RAM as four sequential byte reads, and presents the assembled instruction to the IF/ID pipeline register. It drives the fetch-stall request `req_if` into the pipeline controller and obeys the 6-bit stall vector returned by that controller. Branch redirects from ID enter here.

## Interface
- `RESET_PC`, 32'h00000000, PC loaded on reset
- `NOP_INST`, 32'h00000013, instruction driven when no valid instruction is presented (addi x0,x0,0)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stall`  in  6  controller stall vector: bit1 = IF stalled, bit2 = ID stalled; bits 0 and 5..3 ignored
- `branch_flag`  in  1  ID requests redirect
- `branch_target`  in  32  redirect byte address
- `req_if`  out  1  fetch-stall request to controller, high while fetch in progress
- `mem_rd`  out  1  RAM read enable
- `mem_addr`  out  32  RAM byte address
- `mem_rdata`  in  8  RAM read data, valid exactly 1 cycle after `mem_rd`/`mem_addr`
- `inst`  out  32  instruction to IF/ID
- `inst_pc`  out  32  address of `inst`
- `inst_valid`  out  1  `inst` is real (not NOP filler)
- `misalign`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: `pc` (32), `state` in {FETCH, HOLD}, `cnt` (3 bits, 0..4), `buf` (32).
- `redirect` = `branch_flag & ~stall[2]` (branch taken only in the cycle ID actually advances).
- FETCH, cnt=c:
  - c<4: `mem_rd`=1, `mem_addr`=`pc`+c.
  - c≥1: `buf[8*(c-1)+:8]` <= `mem_rdata` (little-endian: byte at `pc` is `inst[7:0]`).
  - c<4: cnt <= c+1. c=4: state <= HOLD, cnt <= 0.
  - c=0 never captures `mem_rdata`, so a byte returning for an aborted address is discarded.
- HOLD:
  - `mem_rd`=0.
  - `inst`=`buf`, `inst_pc`=`pc`, `inst_valid`=1.
  - If `stall[1]`=0: IF/ID latches this edge; `pc` <= `pc`+4; state <= FETCH, cnt <= 0.
  - If `stall[1]`=1: stay in HOLD; all outputs stable.
- `redirect` in any state or cnt takes priority:
  - `pc` <= target.
  - state <= FETCH, cnt <= 0.
  - `buf` contents are don't-care.
  - In that cycle, if in HOLD, `inst`=`NOP_INST` and `inst_valid`=0, so the wrong-path instruction is squashed.
- Outside HOLD: `inst`=`NOP_INST`, `inst_valid`=0, `inst_pc`=`pc`.
- `req_if` = (state==FETCH). It is decoded from registers only, with no combinational path from `stall` or `branch_flag`, so there is no loop through the controller.
- `pc`+c and `pc`+4 use 32-bit arithmetic and wrap modulo 2^32 (0xFFFFFFFC+4 → 0).

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=FETCH, cnt=0, `buf`=0, `misalign`=0.
  - Outputs in the first cycle after reset: `req_if`=1, `mem_rd`=1, `mem_addr`=`RESET_PC`, `inst`=`NOP_INST`, `inst_valid`=0.
- Unstalled throughput: 5 FETCH cycles + 1 HOLD cycle = 6 cycles per instruction. The first valid `inst` appears in cycle 5 after reset deassertion (cycles numbered from 0).
- Reset mid-fetch or in HOLD: everything returns to reset values on the next edge; partial `buf` is abandoned.
- `redirect` and `stall[1]` high together in HOLD: `redirect` wins.
- `stall` values during FETCH do not stop the byte sequence. The controller stalls IF/ID on `req_if`, not this FSM.

## Configuration
- Macro `IF_FETCH_ALIGN_CHECK_EN`.
- Defined: on `redirect` with `branch_target[1:0]`≠0:
  - `misalign` <= 1, sticky until `rst`.
  - `pc` <= {`branch_target[31:2]`, 2'b00}.
- Undefined:
  - `pc` <= `branch_target` unmodified; byte-granular fetch from any address.
  - `misalign` tied 0.

## Test plan
- Reset, RAM[0..3]=13,05,10,00 → `req_if`=1 in cycles 0–4; in cycle 5 `inst`=0x00100513, `inst_pc`=0, `inst_valid`=1; cycle 6 `mem_addr`=4.
- In HOLD, `stall`=6'b000111 for 3 cycles → HOLD held, `inst`/`inst_pc` stable, `mem_rd`=0. On release the next cycle shows `mem_addr`=4, `req_if`=1.
- During FETCH cnt=2, `branch_flag`=1, target=0x100, `stall[2]`=0 → next cycle `mem_addr`=0x100, cnt=0. After 6 cycles `inst_pc`=0x100 with bytes from 0x100..0x103 only.
- `branch_flag`=1, `stall[2]`=1 for 2 cycles, then `stall[2]`=0 → no redirect during the stalled cycles; redirect to the target after the edge where `stall[2]`=0.
- Redirect in HOLD → same cycle `inst`=0x00000013, `inst_valid`=0. Next `inst_pc` is the target, not `pc`+4.
- Target 0x102 → with macro: `misalign`=1, fetch starts at 0x100. Without macro: `misalign`=0, fetch starts at 0x102.
